// File: rtl/mult_acc_stage.sv
// Accumulates 16-bit approximate-multiplier products into a per-frame sum and
// hands the finished sum, beat count and saturation flag on under valid/ready.
module mult_acc_stage #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;

    logic             w_accept;
    logic             w_release;
    logic [ACC_W:0]   w_sumWide;
    logic             w_accOvf;
    logic             w_cntMax;
    logic [ACC_W-1:0] w_accNext;
    logic [CNT_W-1:0] w_cntNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_ACC: begin
                in_ready = !rst;
                w_accept = in_valid && !rst;
                if (w_accept && in_last) begin
                    w_stateNext = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = !rst;
                w_release = out_ready && !rst;
                if (w_release) begin
                    w_stateNext = ST_ACC;
                end
            end
            default: begin
                w_stateNext = ST_ACC;
            end
        endcase
    end

    // One extra bit of headroom exposes the carry that signals accumulator overflow.
    assign w_sumWide = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, prod};
    assign w_accOvf  = w_sumWide[ACC_W];
    assign w_cntMax  = &r_count;
    assign w_accNext = w_accOvf ? {ACC_W{1'b1}} : w_sumWide[ACC_W-1:0];
    assign w_cntNext = w_cntMax ? r_count : r_count + {{(CNT_W - 1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_accNext;
            r_count <= w_cntNext;
            r_sat   <= r_sat | w_accOvf | w_cntMax;
        end else if (w_release) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end
    end

    assign acc_out   = r_acc;
    assign out_count = r_count;
    assign out_sat   = r_sat;

endmodule
